// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: round-robin arbiter that shares one IP transmit port among
// S_COUNT senders. It grants one sender per packet, registers that sender's
// header, and then passes the payload through until tlast.
module ip_tx_arbiter #(
  parameter  int S_COUNT = 2,
  localparam int GW      = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_COUNT-1:0]      s_ip_hdr_valid,
  output logic [S_COUNT-1:0]      s_ip_hdr_ready,
  input  logic [S_COUNT*6-1:0]    s_ip_dscp,
  input  logic [S_COUNT*2-1:0]    s_ip_ecn,
  input  logic [S_COUNT*16-1:0]   s_ip_length,
  input  logic [S_COUNT*8-1:0]    s_ip_ttl,
  input  logic [S_COUNT*8-1:0]    s_ip_protocol,
  input  logic [S_COUNT*32-1:0]   s_ip_source_ip,
  input  logic [S_COUNT*32-1:0]   s_ip_dest_ip,
  input  logic [S_COUNT*8-1:0]    s_ip_payload_axis_tdata,
  input  logic [S_COUNT-1:0]      s_ip_payload_axis_tvalid,
  output logic [S_COUNT-1:0]      s_ip_payload_axis_tready,
  input  logic [S_COUNT-1:0]      s_ip_payload_axis_tlast,
  input  logic [S_COUNT-1:0]      s_ip_payload_axis_tuser,
  output logic                    m_ip_hdr_valid,
  input  logic                    m_ip_hdr_ready,
  output logic [5:0]              m_ip_dscp,
  output logic [1:0]              m_ip_ecn,
  output logic [15:0]             m_ip_length,
  output logic [7:0]              m_ip_ttl,
  output logic [7:0]              m_ip_protocol,
  output logic [31:0]             m_ip_source_ip,
  output logic [31:0]             m_ip_dest_ip,
  output logic [7:0]              m_ip_payload_axis_tdata,
  output logic                    m_ip_payload_axis_tvalid,
  input  logic                    m_ip_payload_axis_tready,
  output logic                    m_ip_payload_axis_tlast,
  output logic                    m_ip_payload_axis_tuser,
  output logic                    busy,
  output logic                    grant_valid,
  output logic [GW-1:0]           grant_index
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [GW-1:0] r_grantReg;
  logic [GW-1:0] r_lastGrant;
  logic [GW-1:0] w_sel;
  logic          w_found;
  logic [103:0]  w_selHdr;

  // Round-robin search: start just after the last winner and wrap upward.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = 0;
    for (int k = 1; k <= S_COUNT; k++) begin
      idx = (int'(r_lastGrant) + k) % S_COUNT;
      for (int i = 0; i < S_COUNT; i++) begin
        if (!w_found && (i == idx) && s_ip_hdr_valid[i]) begin
          w_found = 1'b1;
          w_sel   = GW'(i);
        end
      end
    end
  end

  // Select the winning lane's header fields as one packed word for capture.
  always_comb begin
    w_selHdr = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (i == int'(w_sel)) begin
        w_selHdr = {s_ip_dscp[i*6 +: 6], s_ip_ecn[i*2 +: 2],
                    s_ip_length[i*16 +: 16], s_ip_ttl[i*8 +: 8],
                    s_ip_protocol[i*8 +: 8], s_ip_source_ip[i*32 +: 32],
                    s_ip_dest_ip[i*32 +: 32]};
      end
    end
  end

  // Next state, per-lane ready steering and payload pass-through; everything idles low while reset is held.
  always_comb begin
    w_nextState              = r_state;
    s_ip_hdr_ready           = '0;
    s_ip_payload_axis_tready = '0;
    m_ip_payload_axis_tdata  = '0;
    m_ip_payload_axis_tvalid = 1'b0;
    m_ip_payload_axis_tlast  = 1'b0;
    m_ip_payload_axis_tuser  = 1'b0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            for (int i = 0; i < S_COUNT; i++) begin
              if (i == int'(w_sel)) begin
                s_ip_hdr_ready[i] = 1'b1;
              end
            end
            w_nextState = HDR;
          end
        end
        HDR: begin
          if (m_ip_hdr_valid && m_ip_hdr_ready) begin
            w_nextState = PAYLOAD;
          end
        end
        PAYLOAD: begin
          for (int i = 0; i < S_COUNT; i++) begin
            if (i == int'(r_grantReg)) begin
              m_ip_payload_axis_tdata     = s_ip_payload_axis_tdata[i*8 +: 8];
              m_ip_payload_axis_tvalid    = s_ip_payload_axis_tvalid[i];
              m_ip_payload_axis_tlast     = s_ip_payload_axis_tlast[i];
              m_ip_payload_axis_tuser     = s_ip_payload_axis_tuser[i];
              s_ip_payload_axis_tready[i] = m_ip_payload_axis_tready;
            end
          end
          if (m_ip_payload_axis_tvalid && m_ip_payload_axis_tready &&
              m_ip_payload_axis_tlast) begin
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State register plus grant memory; last grant starts at the top lane so lane 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grantReg  <= '0;
      r_lastGrant <= GW'(S_COUNT - 1);
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_found) begin
        r_grantReg  <= w_sel;
        r_lastGrant <= w_sel;
      end
    end
  end

  // Header output registers: captured at grant, held until the downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ip_hdr_valid <= 1'b0;
      m_ip_dscp      <= '0;
      m_ip_ecn       <= '0;
      m_ip_length    <= '0;
      m_ip_ttl       <= '0;
      m_ip_protocol  <= '0;
      m_ip_source_ip <= '0;
      m_ip_dest_ip   <= '0;
    end else if (r_state == IDLE && w_found) begin
      m_ip_hdr_valid <= 1'b1;
      {m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl, m_ip_protocol,
       m_ip_source_ip, m_ip_dest_ip} <= w_selHdr;
    end else if (r_state == HDR && m_ip_hdr_ready) begin
      m_ip_hdr_valid <= 1'b0;
    end
  end

  assign busy        = (r_state != IDLE);
  assign grant_valid = (r_state == HDR) || (r_state == PAYLOAD);
  assign grant_index = r_grantReg;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Testbench for ip_tx_arbiter with three requesters: directed scenarios plus
// randomized traffic checked against a packet-level round-robin model.
module tb_ip_tx_arbiter;

  localparam int S  = 3;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [S-1:0]    s_ip_hdr_valid;
  logic [S-1:0]    s_ip_hdr_ready;
  logic [S*6-1:0]  s_ip_dscp;
  logic [S*2-1:0]  s_ip_ecn;
  logic [S*16-1:0] s_ip_length;
  logic [S*8-1:0]  s_ip_ttl;
  logic [S*8-1:0]  s_ip_protocol;
  logic [S*32-1:0] s_ip_source_ip;
  logic [S*32-1:0] s_ip_dest_ip;
  logic [S*8-1:0]  s_ip_payload_axis_tdata;
  logic [S-1:0]    s_ip_payload_axis_tvalid;
  logic [S-1:0]    s_ip_payload_axis_tready;
  logic [S-1:0]    s_ip_payload_axis_tlast;
  logic [S-1:0]    s_ip_payload_axis_tuser;
  logic            m_ip_hdr_valid;
  logic            m_ip_hdr_ready;
  logic [5:0]      m_ip_dscp;
  logic [1:0]      m_ip_ecn;
  logic [15:0]     m_ip_length;
  logic [7:0]      m_ip_ttl;
  logic [7:0]      m_ip_protocol;
  logic [31:0]     m_ip_source_ip;
  logic [31:0]     m_ip_dest_ip;
  logic [7:0]      m_ip_payload_axis_tdata;
  logic            m_ip_payload_axis_tvalid;
  logic            m_ip_payload_axis_tready;
  logic            m_ip_payload_axis_tlast;
  logic            m_ip_payload_axis_tuser;
  logic            busy;
  logic            grant_valid;
  logic [GW-1:0]   grant_index;

  wire [103:0] mHdr = {m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl, m_ip_protocol,
                       m_ip_source_ip, m_ip_dest_ip};
  wire [10:0]  mPay = {m_ip_payload_axis_tdata, m_ip_payload_axis_tvalid,
                       m_ip_payload_axis_tlast, m_ip_payload_axis_tuser};

  int           checks = 0;
  int           errors = 0;
  int           mLast  = S - 1;
  int           mIndex = 0;
  logic [103:0] eHdr [S];

  ip_tx_arbiter #(.S_COUNT(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
    .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length),
    .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
    .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
    .s_ip_payload_axis_tdata(s_ip_payload_axis_tdata),
    .s_ip_payload_axis_tvalid(s_ip_payload_axis_tvalid),
    .s_ip_payload_axis_tready(s_ip_payload_axis_tready),
    .s_ip_payload_axis_tlast(s_ip_payload_axis_tlast),
    .s_ip_payload_axis_tuser(s_ip_payload_axis_tuser),
    .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
    .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_length(m_ip_length),
    .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_ip_payload_axis_tdata(m_ip_payload_axis_tdata),
    .m_ip_payload_axis_tvalid(m_ip_payload_axis_tvalid),
    .m_ip_payload_axis_tready(m_ip_payload_axis_tready),
    .m_ip_payload_axis_tlast(m_ip_payload_axis_tlast),
    .m_ip_payload_axis_tuser(m_ip_payload_axis_tuser),
    .busy(busy), .grant_valid(grant_valid), .grant_index(grant_index)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearInputs();
    s_ip_hdr_valid           = '0;
    s_ip_dscp                = '0;
    s_ip_ecn                 = '0;
    s_ip_length              = '0;
    s_ip_ttl                 = '0;
    s_ip_protocol            = '0;
    s_ip_source_ip           = '0;
    s_ip_dest_ip             = '0;
    s_ip_payload_axis_tdata  = '0;
    s_ip_payload_axis_tvalid = '0;
    s_ip_payload_axis_tlast  = '0;
    s_ip_payload_axis_tuser  = '0;
    m_ip_hdr_ready           = 1'b0;
    m_ip_payload_axis_tready = 1'b0;
  endtask

  task automatic setHdr(input int l, input logic [103:0] h);
    eHdr[l]                    = h;
    s_ip_dscp[l*6 +: 6]        = h[103:98];
    s_ip_ecn[l*2 +: 2]         = h[97:96];
    s_ip_length[l*16 +: 16]    = h[95:80];
    s_ip_ttl[l*8 +: 8]         = h[79:72];
    s_ip_protocol[l*8 +: 8]    = h[71:64];
    s_ip_source_ip[l*32 +: 32] = h[63:32];
    s_ip_dest_ip[l*32 +: 32]   = h[31:0];
  endtask

  function automatic logic [103:0] randHdrVal();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[103:0];
  endfunction

  task automatic setPay(input int l, input logic v, input logic [7:0] d,
                        input logic last, input logic u);
    s_ip_payload_axis_tvalid[l]      = v;
    s_ip_payload_axis_tdata[l*8 +: 8] = d;
    s_ip_payload_axis_tlast[l]       = last;
    s_ip_payload_axis_tuser[l]       = u;
  endtask

  // Reference arbitration: first requester found scanning upward after the last winner.
  function automatic int rrPick(input int last, input logic [S-1:0] req);
    for (int k = 1; k <= S; k++) begin
      if (req[(last + k) % S]) return (last + k) % S;
    end
    return -1;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    clearInputs();
    @(negedge clk);
    rst_n  = 1'b1;
    mLast  = S - 1;
    mIndex = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", busy); end
    checks++;
    if (grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant_valid got %0b expected 0", grant_valid); end
    checks++;
    if (grant_index !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_index got %0d expected 0", grant_index); end
    checks++;
    if (m_ip_hdr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_hdr_valid got %0b expected 0", m_ip_hdr_valid); end
    checks++;
    if (mHdr !== 104'd0) begin errors++; $display("[TB] FAIL reset_hdr_fields got %0h expected 0", mHdr); end
    checks++;
    if (mPay !== 11'd0) begin errors++; $display("[TB] FAIL reset_payload got %0h expected 0", mPay); end
    checks++;
    if ({s_ip_hdr_ready, s_ip_payload_axis_tready} !== '0) begin
      errors++; $display("[TB] FAIL reset_readys got %0h expected 0", {s_ip_hdr_ready, s_ip_payload_axis_tready});
    end
  endtask

  task automatic test_single_packet();
    logic [103:0] saved;
    saved = {6'($urandom), 2'($urandom), 16'd28, 8'd64, 8'd17, 32'($urandom), 32'hC0A8010A};
    @(negedge clk);
    setHdr(1, saved);
    s_ip_hdr_valid = 3'b010;
    #1;
    checks++;
    if (s_ip_hdr_ready !== 3'b010) begin errors++; $display("[TB] FAIL single_hdr_ready got %b expected 010", s_ip_hdr_ready); end
    mLast = 1; mIndex = 1;
    @(negedge clk);
    s_ip_hdr_valid = '0;
    setHdr(1, randHdrVal());
    setPay(1, 1'b1, 8'h00, 1'b0, 1'b0);
    m_ip_hdr_ready           = 1'b1;
    m_ip_payload_axis_tready = 1'b1;
    #1;
    checks++;
    if (s_ip_hdr_ready !== 3'b000) begin errors++; $display("[TB] FAIL single_hdr_pulse got %b expected 000", s_ip_hdr_ready); end
    checks++;
    if (m_ip_hdr_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_hdr_valid got %0b expected 1", m_ip_hdr_valid); end
    checks++;
    if (m_ip_dest_ip !== 32'hC0A8010A || m_ip_length !== 16'd28) begin
      errors++; $display("[TB] FAIL single_dest_len got %h/%0d expected c0a8010a/28", m_ip_dest_ip, m_ip_length);
    end
    checks++;
    if (mHdr !== saved) begin errors++; $display("[TB] FAIL single_hdr_fields got %h expected %h", mHdr, saved); end
    checks++;
    if (grant_index !== 2'd1 || grant_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL single_grant got %0d/%0b expected 1/1", grant_index, grant_valid);
    end
    checks++;
    if (s_ip_payload_axis_tready !== 3'b000 || m_ip_payload_axis_tvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_hdr_blocks_payload got %b/%0b expected 000/0", s_ip_payload_axis_tready, m_ip_payload_axis_tvalid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_ip_hdr_ready = 1'b0;
      setPay(1, 1'b1, 8'(i), i == 7, 1'b0);
      #1;
      checks++;
      if (m_ip_hdr_valid !== 1'b0 || mPay !== {8'(i), 1'b1, 1'(i == 7), 1'b0} ||
          s_ip_payload_axis_tready !== 3'b010) begin
        errors++; $display("[TB] FAIL single_payload_%0d got %h/%b expected %h/010", i, mPay, s_ip_payload_axis_tready, {8'(i), 1'b1, 1'(i == 7), 1'b0});
      end
    end
    @(negedge clk);
    setPay(1, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b0 || grant_valid !== 1'b0 || grant_index !== 2'd1) begin
      errors++; $display("[TB] FAIL single_back_to_idle got %0b/%0b/%0d expected 0/0/1", busy, grant_valid, grant_index);
    end
  endtask

  task automatic test_round_robin();
    int beat [S];
    int grants;
    int cur;
    int cyc;
    int expLane;
    doReset();
    for (int l = 0; l < S; l++) begin
      setHdr(l, randHdrVal());
      beat[l] = 0;
    end
    grants = 0; cur = -1; cyc = 0;
    while (grants < 6 && cyc < 100) begin
      @(negedge clk);
      s_ip_hdr_valid           = '1;
      m_ip_hdr_ready           = 1'b1;
      m_ip_payload_axis_tready = 1'b1;
      for (int l = 0; l < S; l++) setPay(l, 1'b1, 8'(l * 16 + beat[l]), beat[l] == 1, 1'b0);
      #1;
      if (s_ip_hdr_ready !== '0) begin
        expLane = grants % S;
        checks++;
        if (s_ip_hdr_ready !== S'(1 << expLane)) begin
          errors++; $display("[TB] FAIL rr_grant_order grant %0d got %b expected lane %0d", grants, s_ip_hdr_ready, expLane);
        end
        cur = expLane;
        grants++;
      end
      for (int l = 0; l < S; l++) begin
        if (s_ip_payload_axis_tready[l]) begin
          checks++;
          if (l != cur || m_ip_payload_axis_tdata !== 8'(l * 16 + beat[l])) begin
            errors++; $display("[TB] FAIL rr_payload lane %0d got %h expected lane %0d byte %h", l, m_ip_payload_axis_tdata, cur, 8'(l * 16 + beat[l]));
          end
          beat[l] = (beat[l] + 1) % 2;
        end
      end
      cyc++;
    end
    checks++;
    if (grants != 6) begin errors++; $display("[TB] FAIL rr_grant_count got %0d expected 6", grants); end
  endtask

  task automatic test_backpressure();
    logic [103:0] saved;
    logic [7:0]   bytes [10];
    int           rx;
    int           cyc;
    logic         v;
    logic         tr;
    doReset();
    saved = randHdrVal();
    @(negedge clk);
    setHdr(2, saved);
    s_ip_hdr_valid = 3'b100;
    #1;
    checks++;
    if (s_ip_hdr_ready !== 3'b100) begin errors++; $display("[TB] FAIL bp_hdr_ready got %b expected 100", s_ip_hdr_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      s_ip_hdr_valid = '0;
      setHdr(2, randHdrVal());
      #1;
      checks++;
      if (m_ip_hdr_valid !== 1'b1 || mHdr !== saved) begin
        errors++; $display("[TB] FAIL bp_hdr_hold cycle %0d got %0b/%h expected 1/%h", c, m_ip_hdr_valid, mHdr, saved);
      end
    end
    @(negedge clk);
    m_ip_hdr_ready = 1'b1;
    #1;
    checks++;
    if (m_ip_hdr_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hdr_release got %0b expected 1", m_ip_hdr_valid); end
    for (int b = 0; b < 10; b++) bytes[b] = 8'($urandom);
    rx = 0; cyc = 0;
    while (rx < 10 && cyc < 200) begin
      @(negedge clk);
      m_ip_hdr_ready           = 1'b0;
      tr                       = (cyc % 2 == 0);
      m_ip_payload_axis_tready = tr;
      v = ($urandom_range(0, 3) != 0);
      setPay(2, v, bytes[rx], rx == 9, 1'b0);
      #1;
      checks++;
      if (m_ip_payload_axis_tvalid !== v || s_ip_payload_axis_tready !== {tr, 2'b00}) begin
        errors++; $display("[TB] FAIL bp_handshake got %0b/%b expected %0b/%b", m_ip_payload_axis_tvalid, s_ip_payload_axis_tready, v, {tr, 2'b00});
      end
      if (v && tr) begin
        checks++;
        if (m_ip_payload_axis_tdata !== bytes[rx] || m_ip_payload_axis_tlast !== (rx == 9)) begin
          errors++; $display("[TB] FAIL bp_data byte %0d got %h/%0b expected %h/%0b", rx, m_ip_payload_axis_tdata, m_ip_payload_axis_tlast, bytes[rx], rx == 9);
        end
        rx++;
      end
      cyc++;
    end
    checks++;
    if (rx != 10) begin errors++; $display("[TB] FAIL bp_byte_count got %0d expected 10", rx); end
    @(negedge clk);
    setPay(2, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle got %0b expected 0", busy); end
  endtask

  task automatic test_isolation_reset();
    doReset();
    @(negedge clk);
    setHdr(0, randHdrVal());
    s_ip_hdr_valid           = 3'b001;
    m_ip_hdr_ready           = 1'b1;
    m_ip_payload_axis_tready = 1'b1;
    setPay(2, 1'b1, 8'hFF, 1'b0, 1'b0);
    #1;
    checks++;
    if (s_ip_hdr_ready !== 3'b001) begin errors++; $display("[TB] FAIL iso_hdr_ready got %b expected 001", s_ip_hdr_ready); end
    @(negedge clk);
    s_ip_hdr_valid = '0;
    setPay(0, 1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      setPay(0, 1'b1, 8'(16 + i), 1'b0, 1'b0);
      if (i == 2) rst_n = 1'b0;
      #1;
      if (i < 2) begin
        checks++;
        if (s_ip_payload_axis_tready !== 3'b001) begin
          errors++; $display("[TB] FAIL iso_tready byte %0d got %b expected 001", i, s_ip_payload_axis_tready);
        end
        checks++;
        if (m_ip_payload_axis_tdata === 8'hFF || m_ip_payload_axis_tdata !== 8'(16 + i)) begin
          errors++; $display("[TB] FAIL iso_data byte %0d got %h expected %h", i, m_ip_payload_axis_tdata, 8'(16 + i));
        end
      end else begin
        checks++;
        if (busy !== 1'b0 || grant_valid !== 1'b0 || grant_index !== 2'd0 || m_ip_hdr_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL midreset_status got %0b/%0b/%0d/%0b expected 0/0/0/0", busy, grant_valid, grant_index, m_ip_hdr_valid);
        end
        checks++;
        if (mHdr !== 104'd0 || mPay !== 11'd0 || s_ip_payload_axis_tready !== 3'b000) begin
          errors++; $display("[TB] FAIL midreset_outputs got %h/%h/%b expected 0/0/000", mHdr, mPay, s_ip_payload_axis_tready);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    mLast = S - 1; mIndex = 0;
    for (int l = 0; l < S; l++) begin
      setHdr(l, randHdrVal());
      setPay(l, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    s_ip_hdr_valid = '1;
    #1;
    checks++;
    if (s_ip_hdr_ready !== 3'b001) begin errors++; $display("[TB] FAIL midreset_recovery_grant got %b expected 001", s_ip_hdr_ready); end
  endtask

  task automatic test_random_traffic();
    int           lst [S];
    int           len [S];
    int           beat [S];
    int           waitCnt [S];
    logic [7:0]   pay [S][8];
    logic         tvA [S];
    logic         tuA [S];
    logic [S-1:0] req;
    logic [S-1:0] expReady;
    logic [S-1:0] expTr;
    logic         mhr;
    logic         mtr;
    logic         inFlight;
    logic         hdrPend;
    int           cur;
    int           w;
    int           pkts;
    doReset();
    for (int l = 0; l < S; l++) begin lst[l] = 0; len[l] = 1; beat[l] = 0; waitCnt[l] = 0; end
    inFlight = 1'b0; hdrPend = 1'b0; cur = 0; pkts = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int l = 0; l < S; l++) begin
        if (lst[l] == 0 && $urandom_range(0, 3) == 0) begin
          lst[l] = 1; waitCnt[l] = 0; beat[l] = 0;
          len[l] = $urandom_range(1, 6);
          setHdr(l, randHdrVal());
          for (int b = 0; b < 8; b++) pay[l][b] = 8'($urandom);
        end
        req[l] = (lst[l] == 1);
        tvA[l] = (lst[l] != 0) && ($urandom_range(0, 3) != 0);
        tuA[l] = 1'($urandom);
        setPay(l, tvA[l], pay[l][beat[l]], beat[l] == len[l] - 1, tuA[l]);
      end
      s_ip_hdr_valid           = req;
      mhr                      = 1'($urandom);
      mtr                      = 1'($urandom);
      m_ip_hdr_ready           = mhr;
      m_ip_payload_axis_tready = mtr;
      #1;
      expReady = '0;
      if (!inFlight && req != '0) expReady[rrPick(mLast, req)] = 1'b1;
      checks++;
      if (s_ip_hdr_ready !== expReady) begin
        errors++; $display("[TB] FAIL rand_hdr_ready cycle %0d got %b expected %b", cyc, s_ip_hdr_ready, expReady);
      end
      checks++;
      if (busy !== inFlight || grant_valid !== inFlight || grant_index !== GW'(mIndex)) begin
        errors++; $display("[TB] FAIL rand_status cycle %0d got %0b/%0b/%0d expected %0b/%0b/%0d", cyc, busy, grant_valid, grant_index, inFlight, inFlight, mIndex);
      end
      expTr = '0;
      if (inFlight && hdrPend) begin
        checks++;
        if (m_ip_hdr_valid !== 1'b1 || mHdr !== eHdr[cur] || mPay !== 11'd0 || s_ip_payload_axis_tready !== '0) begin
          errors++; $display("[TB] FAIL rand_hdr_phase cycle %0d got %0b/%h/%h expected 1/%h/0", cyc, m_ip_hdr_valid, mHdr, mPay, eHdr[cur]);
        end
      end else if (inFlight) begin
        expTr[cur] = mtr;
        checks++;
        if (m_ip_hdr_valid !== 1'b0 || s_ip_payload_axis_tready !== expTr ||
            mPay !== {pay[cur][beat[cur]], tvA[cur], 1'(beat[cur] == len[cur] - 1), tuA[cur]}) begin
          errors++; $display("[TB] FAIL rand_payload cycle %0d got %h/%b expected lane %0d %h/%b", cyc, mPay, s_ip_payload_axis_tready, cur, {pay[cur][beat[cur]], tvA[cur], 1'(beat[cur] == len[cur] - 1), tuA[cur]}, expTr);
        end
      end else begin
        checks++;
        if (m_ip_hdr_valid !== 1'b0 || mPay !== 11'd0 || s_ip_payload_axis_tready !== '0) begin
          errors++; $display("[TB] FAIL rand_idle cycle %0d got %0b/%h/%b expected 0/0/0", cyc, m_ip_hdr_valid, mPay, s_ip_payload_axis_tready);
        end
      end
      if (!inFlight && req != '0) begin
        w = rrPick(mLast, req);
        for (int l = 0; l < S; l++) begin
          if (l != w && lst[l] == 1) begin
            waitCnt[l]++;
            checks++;
            if (waitCnt[l] > S - 1) begin
              errors++; $display("[TB] FAIL rand_fairness lane %0d waited %0d expected at most %0d", l, waitCnt[l], S - 1);
            end
          end
        end
        lst[w] = 2; cur = w; mLast = w; mIndex = w;
        inFlight = 1'b1; hdrPend = 1'b1;
      end else if (inFlight && hdrPend) begin
        if (mhr) hdrPend = 1'b0;
      end else if (inFlight && tvA[cur] && mtr) begin
        if (beat[cur] == len[cur] - 1) begin
          lst[cur] = 0; inFlight = 1'b0; pkts++;
        end else begin
          beat[cur]++;
        end
      end
    end
    checks++;
    if (pkts < 10) begin errors++; $display("[TB] FAIL rand_progress got %0d packets expected at least 10", pkts); end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_isolation_reset();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_tx_arbiter.md
# ip_tx_arbiter

Round-robin arbiter that shares the single IP transmit input of the `ip` block (`s_ip_hdr_*` / `s_ip_payload_axis_*`) among `S_COUNT` requesters, such as the RTPS/UDP senders. It grants one requester per packet, registers that requester's IP header fields and presents them downstream, then passes its payload through until `tlast`. Its output connects directly to the `ip` block's `s_ip_*` ports.

## Interface

Parameters:
- `S_COUNT`, default 2: number of requesters, legal range 1..8.
- `GW = (S_COUNT>1) ? $clog2(S_COUNT) : 1`: width of `grant_index` (localparam).

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_ip_hdr_valid`  in  S_COUNT  header valid; one bit per requester.
- `s_ip_hdr_ready`  out  S_COUNT  header accept; one bit per requester.
- `s_ip_dscp`  in  S_COUNT*6  DSCP; lane i occupies `[i*6 +: 6]` (all flattened buses use this lane layout).
- `s_ip_ecn`  in  S_COUNT*2  ECN.
- `s_ip_length`  in  S_COUNT*16  IP total length.
- `s_ip_ttl`  in  S_COUNT*8  TTL.
- `s_ip_protocol`  in  S_COUNT*8  protocol.
- `s_ip_source_ip`  in  S_COUNT*32  source IP address.
- `s_ip_dest_ip`  in  S_COUNT*32  destination IP address.
- `s_ip_payload_axis_tdata`  in  S_COUNT*8  payload bytes.
- `s_ip_payload_axis_tvalid`, `s_ip_payload_axis_tlast`, `s_ip_payload_axis_tuser`  in  S_COUNT  payload control.
- `s_ip_payload_axis_tready`  out  S_COUNT  payload ready.
- `m_ip_hdr_valid`  out  1; `m_ip_hdr_ready`  in  1: header handshake toward the `ip` block.
- `m_ip_dscp` (6), `m_ip_ecn` (2), `m_ip_length` (16), `m_ip_ttl` (8), `m_ip_protocol` (8), `m_ip_source_ip` (32), `m_ip_dest_ip` (32)  out: registered header fields.
- `m_ip_payload_axis_tdata` (8), `m_ip_payload_axis_tvalid`, `m_ip_payload_axis_tlast`, `m_ip_payload_axis_tuser`  out; `m_ip_payload_axis_tready`  in: payload stream.
- `busy`  out  1: high whenever the state is not IDLE.
- `grant_valid`  out  1: high in HDR and PAYLOAD.
- `grant_index`  out  GW: index of the current or most recent grant.

## Operation

The block has three states: IDLE, HDR and PAYLOAD.

- **Registers.** The block holds `state`, `grant_reg` and `last_grant`, plus header output registers.
- **Reset values.**
  - `state` = IDLE; `last_grant` = S_COUNT-1, so requester 0 has priority first; `grant_reg` = 0.
  - All `m_ip_*` header registers = 0; `m_ip_hdr_valid` = 0.
  - All `s_*_ready` = 0; `m_ip_payload_axis_*` = 0.
  - `busy` = 0; `grant_valid` = 0; `grant_index` = 0.
- **Arbitration (combinational, IDLE only).**
  - Search `s_ip_hdr_valid` starting at `(last_grant+1) mod S_COUNT` and wrap upward.
  - The first set bit is the winner `sel`.
- **IDLE.**
  - If any `s_ip_hdr_valid` is set: `s_ip_hdr_ready[sel]` = 1 in this same cycle; all other ready bits = 0.
  - At the clock edge: capture lane `sel`'s header fields into the `m_ip_*` registers; set `m_ip_hdr_valid`; set `grant_reg` = `last_grant` = `sel`; go to HDR.
  - If no request is present, all ready bits are 0 and the state stays IDLE.
- **HDR.**
  - `m_ip_hdr_valid` = 1, and the header fields are held stable.
  - On `m_ip_hdr_valid && m_ip_hdr_ready`: clear `m_ip_hdr_valid` and go to PAYLOAD.
  - Payload is blocked: `s_ip_payload_axis_tready` = 0 and `m_ip_payload_axis_tvalid` = 0.
- **PAYLOAD.**
  - Combinational pass-through from lane `grant_reg`: `m_ip_payload_axis_tdata`, `tvalid`, `tlast` and `tuser` come from that lane.
  - `s_ip_payload_axis_tready[grant_reg]` = `m_ip_payload_axis_tready`; all other lanes' tready = 0.
  - A transfer with `tlast` (valid && ready && tlast) moves the state to IDLE.
  - Outside PAYLOAD, the `m_ip_payload_axis_*` outputs are driven to 0.
- **Non-granted lanes.** These stay stalled: no ready on either header or payload, regardless of their valid.
- **Fairness.** A requester that has just been served has the lowest priority in the next arbitration. No input can wait more than S_COUNT-1 packets.
- **S_COUNT = 1.** The block degenerates to a header register plus payload gate; `grant_index` is always 0.

## Timing

- **Header latency.** Header accept happens in cycle t (IDLE). `m_ip_hdr_valid` is high from t+1. If `m_ip_hdr_ready` is high at t+1, payload passes from t+2.
- **Back-to-back packets.** If `tlast` transfers in cycle t, the state is IDLE at t+1, and a new header can be accepted at t+1. This gives a 1-cycle gap plus the header cycle.
- **Simultaneous requests.** Exactly one lane is granted; the rest hold valid until they are served.
- **Requester drops `s_ip_hdr_valid` before grant.** No handshake occurs; the requester is not granted.
- **Payload before header handshake.** Payload presented in HDR is not accepted.
- **`tuser` on `tlast`.** Forwarded unchanged; the arbiter does not interpret it.
- **Asynchronous reset mid-packet.** All outputs return immediately to their reset values; the partial packet is abandoned. Recovery is the downstream `ip` block's responsibility.
- **Header-field changes after accept.** Changes to `s_*` header fields after the accept cycle do not affect the `m_ip_*` outputs.

## Test plan

1. **Reset.** Release reset with `S_COUNT` = 3 and no requests. All outputs must be 0; `grant_index` = 0; `busy` = 0.
2. **Single packet.** Lane 1 sends a header with `dest_ip` 0xC0A8010A and `length` 28, then an 8-byte payload 0x00..0x07 with `tlast` on 0x07.
   - `s_ip_hdr_ready[1]` pulses for one cycle.
   - `m_ip_dest_ip` = 0xC0A8010A the next cycle.
   - 8 bytes pass through in order; the state returns to IDLE.
3. **Round-robin.** All 3 lanes request continuously with 2-byte packets. The grant order must be 0, 1, 2, 0, 1, 2, with no lane skipped.
4. **Backpressure.**
   - Hold `m_ip_hdr_ready` = 0 for 5 cycles: `m_ip_hdr_valid` stays 1 and the header stays stable.
   - Toggle `m_ip_payload_axis_tready` every cycle: no byte may be lost or duplicated.
5. **Isolation.** While lane 0 is in PAYLOAD, lane 2 asserts `tvalid` with data 0xFF. Lane 2's `tready` must stay 0, and 0xFF must never appear on `m_ip_payload_axis_tdata`.
6. **Mid-packet reset.** Assert `rst_n` = 0 at the 3rd payload byte. Outputs must clear in the same cycle. After release, lane 0 is granted first when all lanes request.
